sev_seg_scan_driver: RTL and testbench

//  Time-multiplexed N-digit 7-seg display driver for the ATM front panel.

---
 rtl/sev_seg_pkg.sv | 52 +++++
 rtl/sev_seg_glyph.sv | 12 +
 rtl/sev_seg_scan_driver.sv | 166 ++++++++++++++++
 tb/tb_sev_seg_scan_driver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sev_seg_pkg.sv
// Shared definitions for the seven-segment panel blocks: active-low glyph codes,
// the nibble-to-glyph lookup and a counter-width helper.
package sev_seg_pkg;

    localparam logic [6:0] GLYPH_0    = 7'b0000001;
    localparam logic [6:0] GLYPH_1    = 7'b1001111;
    localparam logic [6:0] GLYPH_2    = 7'b0010010;
    localparam logic [6:0] GLYPH_3    = 7'b0000110;
    localparam logic [6:0] GLYPH_4    = 7'b1001100;
    localparam logic [6:0] GLYPH_5    = 7'b0100100;
    localparam logic [6:0] GLYPH_6    = 7'b0100000;
    localparam logic [6:0] GLYPH_7    = 7'b0001111;
    localparam logic [6:0] GLYPH_8    = 7'b0000000;
    localparam logic [6:0] GLYPH_9    = 7'b0000100;
    localparam logic [6:0] GLYPH_A    = 7'b0001000;
    localparam logic [6:0] GLYPH_B    = 7'b1100000;
    localparam logic [6:0] GLYPH_C    = 7'b0110001;
    localparam logic [6:0] GLYPH_D    = 7'b1000010;
    localparam logic [6:0] GLYPH_E    = 7'b0110000;
    localparam logic [6:0] GLYPH_F    = 7'b0111000;
    localparam logic [6:0] SEG_OFF_AL = 7'b1111111;

    function automatic logic [6:0] glyph_al(input logic [3:0] nibble);
        logic [6:0] code;
        case (nibble)
            4'h0:    code = GLYPH_0;
            4'h1:    code = GLYPH_1;
            4'h2:    code = GLYPH_2;
            4'h3:    code = GLYPH_3;
            4'h4:    code = GLYPH_4;
            4'h5:    code = GLYPH_5;
            4'h6:    code = GLYPH_6;
            4'h7:    code = GLYPH_7;
            4'h8:    code = GLYPH_8;
            4'h9:    code = GLYPH_9;
            4'hA:    code = GLYPH_A;
            4'hB:    code = GLYPH_B;
            4'hC:    code = GLYPH_C;
            4'hD:    code = GLYPH_D;
            4'hE:    code = GLYPH_E;
            4'hF:    code = GLYPH_F;
            default: code = SEG_OFF_AL;
        endcase
        return code;
    endfunction

    // Bits needed to hold 0..n-1; never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sev_seg_glyph.sv
// Combinational nibble to active-low {a..g} code; polarity is left to the caller
// so other panel blocks can share this decoder.
module sev_seg_glyph
    import sev_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_al
);

    assign seg_al = glyph_al(nibble);

endmodule

// File: rtl/sev_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with per-digit enable, leading-zero
// blanking, blink and an anti-ghost dead time at the start of every digit slot.
module sev_seg_scan_driver
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 1000,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_blank,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_tick
);

    localparam int SLOT_W = cnt_w(REFRESH_DIV);
    localparam int IDX_W  = cnt_w(NUM_DIGITS);
    localparam int FRM_W  = cnt_w(BLINK_FRAMES);

    localparam logic [6:0]            SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_IDLE  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = AN_ACTIVE_LOW ? '1 : '0;

    logic [SLOT_W-1:0]       slot_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [FRM_W-1:0]        frame_reg;
    logic                    phase_reg;
    logic [4*NUM_DIGITS-1:0] digits_reg;
    logic [NUM_DIGITS-1:0]   dp_reg;
    logic [NUM_DIGITS-1:0]   en_reg;
    logic [NUM_DIGITS-1:0]   blink_reg;

    logic [6:0]              seg_reg;
    logic                    dp_out_reg;
    logic [NUM_DIGITS-1:0]   an_reg;
    logic                    tick_reg;

    logic                    slot_wrap;
    logic                    idx_wrap;
    logic                    frame_wrap;

    logic [NUM_DIGITS-1:0]   zero_tail;
    logic [NUM_DIGITS-1:0]   digit_blank;
    logic [NUM_DIGITS-1:0]   an_onehot;

    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [6:0]              glyph_code;

    logic [6:0]              seg_al_next;
    logic                    dp_lit_next;
    logic [NUM_DIGITS-1:0]   an_sel_next;
    logic [6:0]              seg_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   an_next;

    assign slot_wrap  = (slot_reg == SLOT_W'(REFRESH_DIV - 1));
    assign idx_wrap   = slot_wrap && (idx_reg == IDX_W'(NUM_DIGITS - 1));
    assign frame_wrap = idx_wrap && (frame_reg == FRM_W'(BLINK_FRAMES - 1));

    // A digit is a leading zero when it and every more-significant nibble are zero;
    // digit 0 is exempt so an all-zero value still shows "0".
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign zero_tail[gi] = ((digits_reg >> (4 * gi)) == '0);
            assign an_onehot[gi] = (idx_reg == IDX_W'(gi));
            if (gi == 0) begin : g_lsd
                assign digit_blank[gi] = !en_reg[gi] || (blink_reg[gi] && phase_reg);
            end else begin : g_upper
                assign digit_blank[gi] = !en_reg[gi] || (blink_reg[gi] && phase_reg) ||
                                         (lz_blank && zero_tail[gi]);
            end
        end
    endgenerate

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                cur_nib   = digits_reg[4*i +: 4];
                cur_dp    = dp_reg[i];
                cur_blank = digit_blank[i];
            end
        end
    end

    sev_seg_glyph u_glyph (
        .nibble (cur_nib),
        .seg_al (glyph_code)
    );

    // Blanked digits keep their anode so every digit gets the same duty cycle.
    always_comb begin
        seg_al_next = SEG_OFF_AL;
        dp_lit_next = 1'b0;
        an_sel_next = '0;
        if (int'(slot_reg) >= BLANK_CYCLES) begin
            an_sel_next = an_onehot;
            if (!cur_blank) begin
                seg_al_next = glyph_code;
                dp_lit_next = cur_dp;
            end
        end
        seg_next = SEG_ACTIVE_LOW ? seg_al_next : ~seg_al_next;
        dp_next  = SEG_ACTIVE_LOW ? ~dp_lit_next : dp_lit_next;
        an_next  = AN_ACTIVE_LOW ? ~an_sel_next : an_sel_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_reg   <= '0;
            idx_reg    <= '0;
            frame_reg  <= '0;
            phase_reg  <= 1'b0;
            digits_reg <= '0;
            dp_reg     <= '0;
            en_reg     <= '0;
            blink_reg  <= '0;
            seg_reg    <= SEG_IDLE;
            dp_out_reg <= DP_IDLE;
            an_reg     <= AN_IDLE;
            tick_reg   <= 1'b0;
        end else begin
            slot_reg <= slot_wrap ? '0 : slot_reg + 1'b1;
            if (slot_wrap) begin
                idx_reg <= idx_wrap ? '0 : idx_reg + 1'b1;
            end
            if (idx_wrap) begin
                frame_reg <= frame_wrap ? '0 : frame_reg + 1'b1;
            end
            if (frame_wrap) begin
                phase_reg <= ~phase_reg;
            end
            if (load) begin
                digits_reg <= digits_in;
                dp_reg     <= dp_in;
                en_reg     <= digit_en;
                blink_reg  <= blink_mask;
            end
            seg_reg    <= seg_next;
            dp_out_reg <= dp_next;
            an_reg     <= an_next;
            tick_reg   <= idx_wrap;
        end
    end

    assign seg_out    = seg_reg;
    assign dp_out     = dp_out_reg;
    assign an_out     = an_reg;
    assign frame_tick = tick_reg;

endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// Bench for sev_seg_scan_driver: an active-low and an active-high build run side by side,
// checked every cycle against a cycle-count model of the scan.
`timescale 1ns/1ps
module tb_sev_seg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [15:0]   digits_in;
    logic [3:0]    dp_in;
    logic [3:0]    digit_en;
    logic [3:0]    blink_mask;
    logic          lz_blank;

    logic [6:0]    seg_al;
    logic          dp_al;
    logic [3:0]    an_al;
    logic          ft_al;
    logic [6:0]    seg_ah;
    logic          dp_ah;
    logic [3:0]    an_ah;
    logic          ft_ah;

    int            err_cnt = 0;
    int            chk_cnt = 0;

    // Reference model state: cycles since reset release plus captured shadow values.
    int            t_model;
    logic [15:0]   m_digits;
    logic [3:0]    m_dp;
    logic [3:0]    m_en;
    logic [3:0]    m_blink;

    logic [6:0]    glyph_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    always #5 clk = ~clk;

    sev_seg_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .digit_en(digit_en), .blink_mask(blink_mask), .lz_blank(lz_blank),
        .seg_out(seg_al), .dp_out(dp_al), .an_out(an_al), .frame_tick(ft_al)
    );

    sev_seg_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) dut_ah (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .digit_en(digit_en), .blink_mask(blink_mask), .lz_blank(lz_blank),
        .seg_out(seg_ah), .dp_out(dp_ah), .an_out(an_ah), .frame_tick(ft_ah)
    );

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t_model, got, exp);
        end
    endtask

    // Active-low pin image {seg, dp, an, frame_tick} for the scan position t cycles after reset.
    function automatic logic [12:0] model_pins(input int t, input logic lz);
        int         slot, idx, frames;
        logic       phase, blank;
        logic [6:0] seg;
        logic       dpv, ft;
        logic [3:0] an;
        logic [3:0] nib;
        slot   = t % RD;
        idx    = (t / RD) % ND;
        frames = t / (RD * ND);
        phase  = ((frames / BF) % 2) == 1;
        ft     = ((t + 1) % (RD * ND)) == 0;
        seg    = 7'h7F;
        dpv    = 1'b1;
        an     = 4'hF;
        if (slot >= BC) begin
            an    = ~(4'(1 << idx));
            nib   = m_digits[idx*4 +: 4];
            blank = !m_en[idx] || (m_blink[idx] && phase) ||
                    (lz && idx != 0 && (m_digits >> (4 * idx)) == 16'h0);
            if (!blank) begin
                seg = glyph_tab[nib];
                dpv = ~m_dp[idx];
            end
        end
        return {seg, dpv, an, ft};
    endfunction

    task automatic step();
        logic [12:0] exp_al;
        @(posedge clk);
        if (!rst_n) begin
            exp_al   = {7'h7F, 1'b1, 4'hF, 1'b0};
            t_model  = 0;
            m_digits = '0;
            m_dp     = '0;
            m_en     = '0;
            m_blink  = '0;
        end else begin
            exp_al = model_pins(t_model, lz_blank);
            if (load) begin
                m_digits = digits_in;
                m_dp     = dp_in;
                m_en     = digit_en;
                m_blink  = blink_mask;
            end
            t_model++;
        end
        #1;
        check("pins_al", {seg_al, dp_al, an_al, ft_al}, exp_al);
        check("pins_ah", {seg_ah, dp_ah, an_ah, ft_ah}, {~exp_al[12:1], exp_al[0]});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                           input logic [3:0] en, input logic [3:0] bl);
        digits_in  = d;
        dp_in      = dp;
        digit_en   = en;
        blink_mask = bl;
        load       = 1'b1;
        $display("load t=%0d digits=%h dp=%b en=%b blink=%b lz=%b", t_model, d, dp, en, bl, lz_blank);
        step();
        load = 1'b0;
    endtask

    initial begin
        t_model    = 0;
        m_digits   = '0;
        m_dp       = '0;
        m_en       = '0;
        m_blink    = '0;
        rst_n      = 1'b0;
        load       = 1'b0;
        digits_in  = '0;
        dp_in      = '0;
        digit_en   = '0;
        blink_mask = '0;
        lz_blank   = 1'b0;

        $display("reset t=%0d", t_model);
        run(2);
        check("rst_al", {seg_al, dp_al, an_al, ft_al}, {7'h7F, 1'b1, 4'hF, 1'b0});
        check("rst_ah", {seg_ah, dp_ah, an_ah, ft_ah}, 13'h0000);
        rst_n = 1'b1;

        // Plain scan of 1234.
        do_load(16'h1234, 4'h0, 4'hF, 4'h0);
        run(70);

        // Leading-zero blanking, including the all-zero value.
        lz_blank = 1'b1;
        do_load(16'h0050, 4'h0, 4'hF, 4'h0);
        run(40);
        do_load(16'h0000, 4'h0, 4'hF, 4'h0);
        run(40);
        lz_blank = 1'b0;

        // Blink on digit 0 across several half-periods, then a disabled digit.
        do_load(16'h1234, 4'h0, 4'hF, 4'b0001);
        run(170);
        do_load(16'h1234, 4'h0, 4'b1011, 4'h0);
        run(40);

        // Inputs move without load: display must hold; then mid-slot load with a dp.
        digits_in = 16'h9876;
        run(40);
        run(3);
        do_load(16'hABCD, 4'b0100, 4'hF, 4'h0);
        run(40);

        // Reset in the middle of digit 2, slot 5.
        for (int i = 0; i < 64; i++) begin
            if (((t_model / RD) % ND) == 2 && (t_model % RD) == 5) break;
            step();
        end
        rst_n = 1'b0;
        $display("reset t=%0d", t_model);
        step();
        rst_n = 1'b1;
        do_load(16'hE0F1, 4'b1001, 4'hF, 4'h0);
        run(40);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                $display("reset t=%0d", t_model);
                step();
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 31) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(0, 15) == 0) begin
                do_load(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            end else begin
                digits_in = 16'($urandom);
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
